// File: rtl/periph_tx_arbiter.sv
// rtl/periph_tx_arbiter.sv - round-robin burst arbiter for four peripheral sources onto one registered 8-bit lane
// Define PERIPH_ARB_PRIO_EN to replace round-robin selection with fixed priority (spi highest).
module periph_tx_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_valid,
   input  logic [3:0] spi_data,
   output logic       spi_ready,
   input  logic       spi2_valid,
   input  logic [1:0] spi2_data,
   output logic       spi2_ready,
   input  logic       uart_valid,
   input  logic [3:0] uart_data,
   output logic       uart_ready,
   input  logic       uart2_valid,
   input  logic [3:0] uart2_data,
   output logic       uart2_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic [1:0] out_src,
   input  logic       out_ready,
   output logic [3:0] grant,
   output logic       busy
);

   typedef enum logic {IDLE, BURST} state_t;

   localparam logic [2:0] LAST_BEAT = 3'(MAX_BURST - 1);

   state_t     state, state_nx;
   logic [1:0] gnt_idx, gnt_nx;
   logic [1:0] last_idx, last_nx;
   logic [2:0] beat_cnt, cnt_nx;
   logic [1:0] win_idx;
   logic [3:0] vld;
   logic [7:0] sel_data;
   logic       g_valid;
   logic       can_take;
   logic       xfer;

   assign vld      = {uart2_valid, uart_valid, spi2_valid, spi_valid};
   assign busy     = (state == BURST);
   assign grant    = busy ? (4'b0001 << gnt_idx) : 4'b0000;
   assign g_valid  = vld[gnt_idx];
   assign can_take = !out_valid || out_ready;
   assign xfer     = busy && g_valid && can_take;

   assign spi_ready   = xfer && (gnt_idx == 2'd0);
   assign spi2_ready  = xfer && (gnt_idx == 2'd1);
   assign uart_ready  = xfer && (gnt_idx == 2'd2);
   assign uart2_ready = xfer && (gnt_idx == 2'd3);

`ifdef PERIPH_ARB_PRIO_EN
   always_comb begin
      win_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (vld[i]) win_idx = 2'(i);
      end
   end
`else
   logic       found;
   logic [1:0] cand_idx;

   // Search starts just past the previous owner, wrapping mod 4.
   always_comb begin
      win_idx  = 2'd0;
      found    = 1'b0;
      cand_idx = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand_idx = last_idx + 2'(k);
         if (!found && vld[cand_idx]) begin
            win_idx = cand_idx;
            found   = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      sel_data = 8'h00;
      case (gnt_idx)
         2'd0:    sel_data = {4'h0, spi_data};
         2'd1:    sel_data = {6'h00, spi2_data};
         2'd2:    sel_data = {4'h0, uart_data};
         default: sel_data = {4'h0, uart2_data};
      endcase
   end

   always_comb begin
      state_nx = state;
      gnt_nx   = gnt_idx;
      last_nx  = last_idx;
      cnt_nx   = beat_cnt;
      case (state)
         IDLE: begin
            if (|vld) begin
               gnt_nx   = win_idx;
               cnt_nx   = 3'd0;
               state_nx = BURST;
            end
         end
         default: begin
            // A dropped valid ends the burst without taking a beat.
            if (!g_valid) begin
               state_nx = IDLE;
               last_nx  = gnt_idx;
            end else if (xfer) begin
               cnt_nx = beat_cnt + 3'd1;
               if (beat_cnt == LAST_BEAT) begin
                  state_nx = IDLE;
                  last_nx  = gnt_idx;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt_idx  <= 2'd0;
         last_idx <= 2'd3;
         beat_cnt <= 3'd0;
      end else begin
         state    <= state_nx;
         gnt_idx  <= gnt_nx;
         last_idx <= last_nx;
         beat_cnt <= cnt_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_src   <= 2'd0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_src   <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_periph_tx_arbiter.sv
// tb/tb_periph_tx_arbiter.sv - randomized scoreboard bench for periph_tx_arbiter
module tb_periph_tx_arbiter;
   localparam int MB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] vv = 4'h0;
   logic [3:0] dd [4];
   logic       out_ready = 1'b0;

   logic       spi_ready, spi2_ready, uart_ready, uart2_ready;
   logic       out_valid, busy;
   logic [7:0] out_data;
   logic [1:0] out_src;
   logic [3:0] grant;

   always #5 clk = ~clk;

   periph_tx_arbiter #(.MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_valid(vv[0]),   .spi_data(dd[0]),        .spi_ready(spi_ready),
      .spi2_valid(vv[1]),  .spi2_data(dd[1][1:0]),  .spi2_ready(spi2_ready),
      .uart_valid(vv[2]),  .uart_data(dd[2]),       .uart_ready(uart_ready),
      .uart2_valid(vv[3]), .uart2_data(dd[3]),      .uart2_ready(uart2_ready),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready), .grant(grant), .busy(busy)
   );

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner of the lane (-1 = nobody), previous owner, beats taken.
   int         owner = -1;
   int         last = 3;
   int         cnt = 0;
   bit         m_ov = 1'b0;
   logic [3:0] m_took = 4'h0;
   logic [9:0] q[$];

   function automatic int pick(input logic [3:0] v, input int l);
      int idx;
`ifdef PERIPH_ARB_PRIO_EN
      for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
      for (int k = 1; k <= 4; k++) begin
         idx = (l + k) % 4;
         if (v[idx]) return idx;
      end
`endif
      return -1;
   endfunction

   always @(negedge clk) begin : model
      logic [3:0] er;
      logic [3:0] eg;
      logic [7:0] ed;
      bit         take;
      er = 4'h0;
      m_took = 4'h0;
      if (!rst_n) begin
         check("ready_in_reset", {uart2_ready, uart_ready, spi2_ready, spi_ready}, 0);
         check("out_valid_in_reset", out_valid, 0);
         owner = -1; last = 3; cnt = 0; m_ov = 1'b0;
         q.delete();
      end else begin
         take = (owner >= 0) && vv[owner] && (!m_ov || out_ready);
         if (take) er[owner] = 1'b1;
         eg = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
         check("ready", {uart2_ready, uart_ready, spi2_ready, spi_ready}, er);
         check("grant", grant, eg);
         check("busy", busy, owner >= 0);
         check("out_valid", out_valid, m_ov);
         if (owner < 0) begin
            if (|vv) begin
               owner = pick(vv, last);
               cnt = 0;
            end
         end else if (!vv[owner]) begin
            last = owner;
            owner = -1;
         end else if (take) begin
            ed = (owner == 1) ? {6'h00, dd[1][1:0]} : {4'h0, dd[owner]};
            q.push_back({2'(owner), ed});
            m_took[owner] = 1'b1;
            cnt++;
            if (cnt == MB) begin
               last = owner;
               owner = -1;
            end
         end
         if (take) m_ov = 1'b1;
         else if (out_ready) m_ov = 1'b0;
      end
   end

   always @(negedge clk) begin : monitor
      logic [9:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_beat", {out_src, out_data}, 10'h3ff);
         end else begin
            e = q.pop_front();
            check("beat_src", out_src, e[9:8]);
            check("beat_data", out_data, e[7:0]);
         end
      end
   end

   task automatic step_sources();
      for (int i = 0; i < 4; i++) begin
         if (vv[i] && m_took[i]) begin
            vv[i] = $urandom_range(0, 1);
            dd[i] = 4'($urandom);
         end else if (vv[i]) begin
            if ($urandom_range(0, 7) == 0) vv[i] = 1'b0;
         end else if ($urandom_range(0, 1) == 1) begin
            vv[i] = 1'b1;
            dd[i] = 4'($urandom);
         end
      end
      out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic run_random(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         step_sources();
      end
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 4; i++) dd[i] = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_src", out_src, 0);
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      #2 rst_n = 1'b1;

      // spi alone: grant on the next cycle, four beats of 0x0A, then a bubble.
      @(posedge clk); #1;
      vv = 4'b0001; dd[0] = 4'hA; out_ready = 1'b1;
      @(posedge clk); #1;
      check("spi_first_grant", grant, 4'b0001);
      repeat (12) @(posedge clk);
      #1 vv = 4'h0;
      repeat (3) @(posedge clk);

      // uart burst with a three-cycle sink stall.
      #1 vv = 4'b0100; dd[2] = 4'h1;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1;
         if (m_took[2]) dd[2] = dd[2] + 4'h1;
         out_ready = !(c >= 3 && c <= 5);
      end
      vv = 4'h0; out_ready = 1'b1;
      repeat (3) @(posedge clk);

      run_random(2000);

      // Asynchronous reset in the middle of a burst holding a beat.
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         @(posedge clk); #1;
         if (busy && out_valid) found = 1'b1;
         else step_sources();
      end
      check("found_midburst", found, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_grant", grant, 0);
      check("async_busy", busy, 0);
      vv = 4'hF;
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_grant", grant, 4'b0001);

      run_random(2000);

      #1 vv = 4'h0; out_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("drain", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/periph_tx_arbiter.md
# periph_tx_arbiter

Round-robin arbiter that shares one registered 8-bit transmit lane between four peripheral sources: spi (4-bit), spi2 (2-bit), uart (4-bit), uart2 (4-bit). Each source uses a valid/ready handshake. A granted source keeps the lane for a burst of up to MAX_BURST beats. The block sits between the peripheral data generators and the single shared output sink, and tags every beat with its source index.

## Interface
Parameters:
- MAX_BURST, 4: maximum beats per grant; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- spi_valid  in  1  source 0 has a beat.
- spi_data  in  4  source 0 payload.
- spi_ready  out  1  source 0 beat accepted this cycle.
- spi2_valid / spi2_data / spi2_ready  in/in/out  1/2/1  source 1 handshake and payload.
- uart_valid / uart_data / uart_ready  in/in/out  1/4/1  source 2 handshake and payload.
- uart2_valid / uart2_data / uart2_ready  in/in/out  1/4/1  source 3 handshake and payload.
- out_valid  out  1  shared lane holds a beat.
- out_data  out  8  beat payload, zero-extended from the source width.
- out_src  out  2  source index of the beat: 0=spi, 1=spi2, 2=uart, 3=uart2.
- out_ready  in  1  sink accepts the beat.
- grant  out  4  one-hot current grant; 0 in IDLE.
- busy  out  1  high in state BURST.

## Operation
- FSM has two states, IDLE and BURST. The registers are: state, gnt_idx[1:0], last_idx[1:0], beat_cnt[2:0], and the output register (out_valid, out_data, out_src).
- IDLE:
  - If any valid is high, select the winner, load gnt_idx, clear beat_cnt and go to BURST.
  - Otherwise stay in IDLE.
  - No ready is asserted in IDLE.
- Winner selection: first asserted valid, searching from last_idx+1 upward mod 4.
- BURST:
  - Only the granted source can see ready: x_ready = grant[x] & x_valid & (!out_valid | out_ready).
  - A transfer is a cycle with x_valid & x_ready. On a transfer, the output register loads {zero-ext data, gnt_idx} and beat_cnt increments.
  - Exit to IDLE and set last_idx=gnt_idx in either case:
    - a transfer occurs with beat_cnt==MAX_BURST-1;
    - the granted source's valid is low in any BURST cycle. The grant is released immediately and no beat is taken.
- Output register:
  - out_valid sets on a transfer.
  - out_valid clears when out_ready is high and there is no transfer in the same cycle.
  - If a transfer and out_ready both occur in the same cycle, the register reloads with the new beat; there is no bubble.
- Backpressure: while out_valid & !out_ready, no source gets ready. The burst is held, beat_cnt is frozen, and the grant is kept as long as the granted valid stays high.
- Source protocol: a source holds data stable while valid & !ready. A source may drop valid before acceptance; the arbiter treats that as the end of the burst.
- MAX_BURST=1: every beat is followed by IDLE, giving pure per-beat round-robin.

## Timing
- Reset values: state=IDLE, gnt_idx=0, last_idx=3 (so spi has first priority), beat_cnt=0, out_valid=0, out_data=0, out_src=0, grant=0, busy=0. All ready outputs are 0.
- Reset is asynchronous and may hit mid-burst. Any beat in flight is discarded and no ready is asserted while rst_n is low.
- Latency:
  - A valid seen in cycle N (IDLE) gives busy/grant in N+1.
  - The first transfer happens in N+1 if the sink is free.
  - out_valid is seen in N+2.
- Throughput:
  - 1 beat/cycle inside a burst.
  - One IDLE bubble cycle between consecutive bursts.
- The ready outputs are combinational from out_ready, out_valid, grant and the valid inputs. grant and busy are registered.

## Configuration
- PERIPH_ARB_PRIO_EN:
  - Defined: winner selection is fixed priority (spi > spi2 > uart > uart2), and last_idx is ignored.
  - Undefined (default): round-robin as described above.
- Burst length, backpressure and timing are identical in both builds.

## Test plan
- Reset, then only spi_valid=1 with spi_data=4'hA and out_ready=1, MAX_BURST=4:
  - grant=4'b0001 on cycle 1.
  - Four beats out_data=8'h0A with out_src=0.
  - One IDLE cycle, then a new grant to spi.
- All four valids held high, out_ready=1, MAX_BURST=2:
  - Grant order spi, spi2, uart, uart2, spi.
  - Each grant carries 2 beats.
  - spi2 beats are zero-extended: data 2'b11 appears as 8'h03.
- uart bursting, out_ready=0 for 3 cycles mid-burst:
  - uart_ready=0 during the stall and out_data is stable.
  - beat_cnt is frozen and the burst resumes with no lost or duplicated beat.
- uart2 granted, uart2_valid dropped after 1 beat:
  - busy falls the next cycle.
  - last_idx=3, so the next grant goes to spi.
- rst_n pulsed low mid-burst with out_valid=1:
  - out_valid, grant and busy are 0 immediately, asynchronously.
  - After release, the first grant goes to spi.
- With PERIPH_ARB_PRIO_EN defined and spi and uart2 continuously valid:
  - Every grant goes to spi and uart2 never receives ready.
